ioport_bank: RTL

- Four-port memory-mapped I/O register bank. Sits directly downstream of the CPU data-memory address decoder.
- Consumes the decoder's one-hot per-port write enables and the 2-bit port read select.
- Drives registered outputs to board devices (LEDs, 7-seg) and returns synchronized board inputs (switches, buttons) to the CPU read mux.
- Read data is combinational from registered state, so single-cycle loads work unchanged.

---
 rtl/ioport_pkg.sv | 11 +
 rtl/ioport_bank_if.sv | 14 +
 rtl/ioport_bank_sync_ff.sv | 25 ++
 rtl/ioport_bank.sv | 82 ++++++++
 4 files changed

// File: rtl/ioport_pkg.sv
// ioport_pkg: shared I/O port bank constants and port-index names.
package ioport_pkg;
  localparam int NUM_IOPORTS = 4;
  localparam int IOPORT_SEL_W = 2;
  typedef enum logic [IOPORT_SEL_W-1:0] {
    IOPORT0 = 2'd0,
    IOPORT1 = 2'd1,
    IOPORT2 = 2'd2,
    IOPORT3 = 2'd3
  } ioport_idx_e;
endpackage

// File: rtl/ioport_bank_if.sv
// ioport_bank_if: CPU-side decoder bus into the I/O port bank.
interface ioport_bank_if
  import ioport_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [NUM_IOPORTS-1:0]  ioport_we;
  logic [IOPORT_SEL_W-1:0] ioport_rd_sel;
  logic                    rd_en;
  logic [WIDTH-1:0]        wr_data;
  logic [WIDTH-1:0]        rd_data;
  modport master (output ioport_we, ioport_rd_sel, rd_en, wr_data, input rd_data);
  modport slave (input ioport_we, ioport_rd_sel, rd_en, wr_data, output rd_data);
endinterface

// File: rtl/ioport_bank_sync_ff.sv
// sync_ff: multi-stage flop synchronizer for quasi-static board inputs.
module sync_ff #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end
  assign q = stage_q[STAGES-1];
endmodule

// File: rtl/ioport_bank.sv
// ioport_bank: four-port memory-mapped I/O register bank with synchronized inputs.
// Define IOPORT_CHANGE_DETECT_EN to add the sticky per-port changed flags.
module ioport_bank
  import ioport_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  ioport_bank_if.slave     bus,
  input  logic [WIDTH-1:0] port_in0,
  input  logic [WIDTH-1:0] port_in1,
  input  logic [WIDTH-1:0] port_in2,
  input  logic [WIDTH-1:0] port_in3,
  output logic [WIDTH-1:0] port_out0,
  output logic [WIDTH-1:0] port_out1,
  output logic [WIDTH-1:0] port_out2,
  output logic [WIDTH-1:0] port_out3
`ifdef IOPORT_CHANGE_DETECT_EN
  ,
  output logic [NUM_IOPORTS-1:0] changed
`endif
);
  logic [WIDTH-1:0] in_w   [NUM_IOPORTS];
  logic [WIDTH-1:0] sync_w [NUM_IOPORTS];
  logic [WIDTH-1:0] out_q  [NUM_IOPORTS];
  logic [WIDTH-1:0] out_d  [NUM_IOPORTS];
  assign in_w = '{port_in0, port_in1, port_in2, port_in3};
  genvar g;
  for (g = 0; g < NUM_IOPORTS; g++) begin : g_sync
    sync_ff #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (in_w[g]),
      .q    (sync_w[g])
    );
  end
  // a multi-hot enable writes every selected port with the same data
  always_comb begin
    for (int n = 0; n < NUM_IOPORTS; n++) out_d[n] = bus.ioport_we[n] ? bus.wr_data : out_q[n];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_IOPORTS; n++) out_q[n] <= OUT_RESET;
    end else begin
      out_q <= out_d;
    end
  end
  assign port_out0   = out_q[0];
  assign port_out1   = out_q[1];
  assign port_out2   = out_q[2];
  assign port_out3   = out_q[3];
  assign bus.rd_data = sync_w[bus.ioport_rd_sel];
`ifdef IOPORT_CHANGE_DETECT_EN
  logic [WIDTH-1:0]       prev_q [NUM_IOPORTS];
  logic [WIDTH-1:0]       prev_d [NUM_IOPORTS];
  logic [NUM_IOPORTS-1:0] changed_q;
  logic [NUM_IOPORTS-1:0] changed_d;
  assign prev_d = sync_w;
  // set dominates clear so a change landing in the read cycle is not lost
  always_comb begin
    for (int n = 0; n < NUM_IOPORTS; n++)
      changed_d[n] = (sync_w[n] != prev_q[n]) |
                     (changed_q[n] & ~(bus.rd_en & (bus.ioport_rd_sel == IOPORT_SEL_W'(n))));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_IOPORTS; n++) prev_q[n] <= '0;
      changed_q <= '0;
    end else begin
      prev_q    <= prev_d;
      changed_q <= changed_d;
    end
  end
  assign changed = changed_q;
`else
  logic unused_rd_en;
  assign unused_rd_en = bus.rd_en;
`endif
endmodule
